// File: rtl/sc_fb_pkg.sv
// Shared sizing, band packing and threshold helper for the stochastic filter bank.
package sc_fb_pkg;

    localparam int N     = 12;
    localparam int FRAME = 1 << N;
    localparam int IN_W  = 4*N - 5;

    localparam int B0_W = N;
    localparam int B1_W = N - 1;
    localparam int B2_W = N - 2;
    localparam int B3_W = N - 2;

    localparam int B0_LSB = 0;
    localparam int B1_LSB = N;
    localparam int B2_LSB = 2*N - 1;
    localparam int B3_LSB = 3*N - 3;

    typedef logic [N-1:0] word_t;

    typedef struct packed {
        logic [B3_W-1:0] b3;
        logic [B2_W-1:0] b2;
        logic [B1_W-1:0] b1;
        logic [B0_W-1:0] b0;
    } bands_t;

    function automatic word_t bitrev(input word_t x);
        word_t r;
        for (int i = 0; i < N; i++) begin
            r[i] = x[N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_vdc_counter.sv
// Free-running frame counter with van der Corput threshold, quarter index and frame-end flag.
// Zero latency on outputs (combinational from the count); never stalls.
module sc_vdc_counter
    import sc_fb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [1:0]  sel_o,
    output word_t       thr_o,
    output logic        last_o
);

    word_t cnt_q;
    word_t cnt_d;

    always_comb begin
        cnt_d = cnt_q + word_t'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sel_o  = cnt_q[N-1:N-2];
    assign thr_o  = bitrev(cnt_q);
    assign last_o = (cnt_q == word_t'(FRAME - 1));

endmodule

// File: rtl/sc_synth_merge.sv
// Zero-order-hold upsample of four subbands, stochastic MUX-add, decode once per 2^N-cycle frame.
// Output one cycle after frame end; input accepted only in the last frame cycle, no buffering.
module sc_synth_merge
    import sc_fb_pkg::*;
(
    input  logic            clock,
    input  logic            start,
    input  logic [IN_W-1:0] in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N-1:0]    out,
    output logic            out_valid
);

    logic [1:0] sel;
    word_t      thr;
    logic       last;

    bands_t     bands_q, bands_d;
    word_t      acc_q, acc_d;
    word_t      out_q, out_d;
    logic       ov_q, ov_d;
    logic [2:0] fidx_q, fidx_d;

    logic [2:0] phase;
    word_t      b_sel;
    word_t      s_ext;
    logic       load;

    sc_vdc_counter u_cnt (
        .clk_i  (clock),
        .rst_i  (start),
        .sel_o  (sel),
        .thr_o  (thr),
        .last_o (last)
    );

    assign in_ready = last & ~start;
    assign load     = in_ready & in_valid;
    // Phase of the frame that begins right after this boundary.
    assign phase    = fidx_q + 3'd1;

    always_comb begin
        case (sel)
            2'd0:    b_sel = bands_q.b0;
            2'd1:    b_sel = {bands_q.b1, 1'b0};
            2'd2:    b_sel = {bands_q.b2, 2'b00};
            default: b_sel = {bands_q.b3, 2'b00};
        endcase
    end

    assign s_ext = {{(N-1){1'b0}}, (b_sel > thr)};

    always_comb begin
        bands_d = bands_q;
        acc_d   = acc_q + s_ext;
        out_d   = out_q;
        ov_d    = 1'b0;
        fidx_d  = fidx_q;
        if (last) begin
            acc_d  = '0;
            out_d  = acc_q + s_ext;
            ov_d   = 1'b1;
            fidx_d = phase;
        end
        // Slower bands only refresh on phases aligned to their decimation ratio.
        if (load) begin
            bands_d.b0 = in[B0_LSB +: B0_W];
            if (phase[0] == 1'b0) begin
                bands_d.b1 = in[B1_LSB +: B1_W];
            end
            if (phase[1:0] == 2'b00) begin
                bands_d.b2 = in[B2_LSB +: B2_W];
            end
            if (phase == 3'b000) begin
                bands_d.b3 = in[B3_LSB +: B3_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            bands_q <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            fidx_q  <= '0;
        end else begin
            bands_q <= bands_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            fidx_q  <= fidx_d;
        end
    end

    assign out       = out_q;
    assign out_valid = ov_q;

endmodule
